// File: rtl/adc_pingpong_capture.sv
// Multichannel ADC capture into a two-bank ping-pong DPBRAM with per-bank
// full flags, overrun detection and a power-of-two block averager.
module adc_pingpong_capture #(
    parameter int CH_NUM       = 2,
    parameter int DWIDTH       = 24,
    parameter int RAM_DEPTH    = 20000,
    parameter int AVG_LOG2_MAX = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic                           i_mode,
    input  logic                           i_adc_valid,
    input  logic [CH_NUM*DWIDTH-1:0]       i_adc_data,
    input  logic [3:0]                     i_avg_shift,
    input  logic [1:0]                     i_flag_clr,
    output logic [$clog2(RAM_DEPTH)-1:0]   o_ram_addr,
    output logic                           o_ram_ce,
    output logic                           o_ram_we,
    output logic [CH_NUM*DWIDTH-1:0]       o_ram_dout,
    output logic [1:0]                     o_bank_flag,
    output logic                           o_overrun,
    output logic [CH_NUM*32-1:0]           o_avg_data,
    output logic                           o_avg_valid,
    output logic [1:0]                     o_debug_state
);

    localparam int AW    = $clog2(RAM_DEPTH);
    localparam int ACC_W = DWIDTH + AVG_LOG2_MAX;
    localparam int CNT_W = AVG_LOG2_MAX + 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(RAM_DEPTH - 1);
    localparam logic [AW-1:0] ADDR_HALF = AW'(RAM_DEPTH / 2 - 1);
    localparam logic [3:0]    N_MAX     = 4'(AVG_LOG2_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       w_write;
    logic                       w_avg_en;
    logic [AW-1:0]              w_wr_addr;
    logic [1:0]                 w_flag_ev;
    logic [3:0]                 w_n_eff;
    logic [CNT_W-1:0]           w_blk_last;
    logic signed [ACC_W-1:0]    w_samp [CH_NUM];
    logic signed [ACC_W-1:0]    w_sum  [CH_NUM];

    logic                       r_ce_p1;
    logic [AW-1:0]              r_addr_p1;
    logic [CH_NUM*DWIDTH-1:0]   r_dout_p1;
    logic [1:0]                 r_flag;
    logic                       r_overrun;
    logic signed [ACC_W-1:0]    r_acc [CH_NUM];
    logic [CNT_W-1:0]           r_avg_cnt;
    logic [3:0]                 r_avg_n;
    logic [CH_NUM*32-1:0]       r_avg_data_p1;
    logic                       r_avg_vld_p1;

    function automatic logic [3:0] f_clamp(input logic [3:0] n);
        return (n > N_MAX) ? N_MAX : n;
    endfunction

    // Floor-mean: sign-extend first, then arithmetic shift.
    function automatic logic [31:0] f_mean(input logic signed [ACC_W-1:0] s,
                                           input logic [3:0] n);
        logic signed [31:0] v;
        v = 32'(s);
        return v >>> n;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_write     = (r_state == RUN) && i_en && i_adc_valid;
        w_avg_en    = (r_state != IDLE) && i_en && i_adc_valid;
        if (!i_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = RUN;
                RUN:     if (w_write && i_mode && (w_wr_addr == ADDR_LAST)) w_state_nxt = DONE;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // The address register shows the write address during o_ram_ce and
    // advances once that write has been presented.
    always_comb begin
        w_wr_addr = r_addr_p1;
        if (r_ce_p1) w_wr_addr = (r_addr_p1 == ADDR_LAST) ? '0 : r_addr_p1 + AW'(1);
        w_flag_ev[0] = r_ce_p1 && (r_addr_p1 == ADDR_HALF);
        w_flag_ev[1] = r_ce_p1 && (r_addr_p1 == ADDR_LAST);
        w_n_eff      = (r_avg_cnt == '0) ? f_clamp(i_avg_shift) : r_avg_n;
        w_blk_last   = (CNT_W'(1) << w_n_eff) - CNT_W'(1);
        for (int k = 0; k < CH_NUM; k++) begin
            w_samp[k] = ACC_W'($signed(i_adc_data[k*DWIDTH +: DWIDTH]));
            w_sum[k]  = r_acc[k] + w_samp[k];
        end
    end

    // Stage p1: RAM write port
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ce_p1   <= 1'b0;
            r_addr_p1 <= '0;
            r_dout_p1 <= '0;
        end else begin
            r_ce_p1   <= w_write;
            r_addr_p1 <= i_en ? w_wr_addr : '0;
            if (w_write) r_dout_p1 <= i_adc_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_flag    <= 2'b00;
            r_overrun <= 1'b0;
        end else begin
            r_flag    <= w_flag_ev | (r_flag & ~i_flag_clr);
            r_overrun <= i_en ? (r_overrun | (|(w_flag_ev & r_flag))) : 1'b0;
        end
    end

    // Stage p1: block averager output
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_avg_cnt     <= '0;
            r_avg_n       <= 4'd0;
            r_avg_data_p1 <= '0;
            r_avg_vld_p1  <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) r_acc[k] <= '0;
        end else begin
            r_avg_vld_p1 <= 1'b0;
            if (!i_en || (r_state == IDLE)) begin
                r_avg_cnt <= '0;
                for (int k = 0; k < CH_NUM; k++) r_acc[k] <= '0;
            end else if (w_avg_en) begin
                if (r_avg_cnt == '0) r_avg_n <= w_n_eff;
                if (r_avg_cnt == w_blk_last) begin
                    r_avg_cnt    <= '0;
                    r_avg_vld_p1 <= 1'b1;
                    for (int k = 0; k < CH_NUM; k++) begin
                        r_acc[k]                   <= '0;
                        r_avg_data_p1[k*32 +: 32] <= f_mean(w_sum[k], w_n_eff);
                    end
                end else begin
                    r_avg_cnt <= r_avg_cnt + CNT_W'(1);
                    for (int k = 0; k < CH_NUM; k++) r_acc[k] <= w_sum[k];
                end
            end
        end
    end

    assign o_ram_addr    = r_addr_p1;
    assign o_ram_ce      = r_ce_p1;
    assign o_ram_we      = 1'b1;
    assign o_ram_dout    = r_dout_p1;
    assign o_bank_flag   = r_flag;
    assign o_overrun     = r_overrun;
    assign o_avg_data    = r_avg_data_p1;
    assign o_avg_valid   = r_avg_vld_p1;
    assign o_debug_state = r_state;

endmodule
